// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the ID-stage register file. It covers the boot/re-init sweep,
// writeback-first arbitration, and a small NPU result FIFO with WAW kill and RAW detect.
module regfile_wr_arbiter #(
   parameter int NPU_DEPTH = 2
) (
   input  logic        clk_50,
   input  logic        rst,
   input  logic        init_req,
   output logic [4:0]  init_addr,
   input  logic [31:0] init_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_wr,
   input  logic [31:0] wb_wd,
   input  logic        npu_valid,
   input  logic [4:0]  npu_wr,
   input  logic [31:0] npu_wd,
   output logic        npu_ready,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        npu_raw,
   output logic [4:0]  WR,
   output logic [31:0] WD,
   output logic        RegWrite,
   output logic        stall,
   output logic        init_done
);

   localparam int PW = (NPU_DEPTH > 1) ? $clog2(NPU_DEPTH) : 1;
   localparam int CW = $clog2(NPU_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(NPU_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(NPU_DEPTH);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [NPU_DEPTH-1:0] live_q, live_d;
   logic [4:0]           ent_wr_q [NPU_DEPTH];
   logic [31:0]          ent_wd_q [NPU_DEPTH];

   logic port_on;
   logic fifo_empty;
   logic fifo_full;
   logic wb_act;
   logic head_live;
   logic pop;
   logic push;
   logic enq;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // A killed head leaves regardless of WB; a live head only takes an idle slot.
   always_comb begin
      port_on    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q >= DEPTH_C);
      wb_act     = port_on && wb_we && (wb_wr != 5'd0);
      head_live  = !fifo_empty && live_q[head_q];
      pop        = port_on && !fifo_empty && (!wb_act || !live_q[head_q]);
      npu_ready  = (state_q == ST_RUN) && !fifo_full;
      push       = npu_valid && npu_ready;
      enq        = push && (npu_wr != 5'd0);
   end

   always_comb begin
      RegWrite = 1'b0;
      WR       = 5'd0;
      WD       = 32'd0;
      if (state_q == ST_INIT) begin
         RegWrite = 1'b1;
         WR       = cnt_q;
         WD       = (cnt_q == 5'd0) ? 32'd0 : init_data;
      end else if (wb_act) begin
         RegWrite = 1'b1;
         WR       = wb_wr;
         WD       = wb_wd;
      end else if (head_live) begin
         RegWrite = 1'b1;
         WR       = ent_wr_q[head_q];
         WD       = ent_wd_q[head_q];
      end
   end

   always_comb begin
      init_addr = cnt_q;
      stall     = (state_q != ST_RUN);
      init_done = (state_q == ST_RUN);
   end

   // Entries pushed this cycle are not yet visible to the hazard check.
   always_comb begin
      npu_raw = 1'b0;
      if (state_q == ST_RUN) begin
         for (int i = 0; i < NPU_DEPTH; i++) begin
            if (live_q[i] && (ent_wr_q[i] != 5'd0) &&
                ((ent_wr_q[i] == rs1) || (ent_wr_q[i] == rs2))) begin
               npu_raw = 1'b1;
            end
         end
      end
   end

   // WB is program-order newer, so it invalidates older queued results for the same register.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      live_d  = live_q;
      for (int i = 0; i < NPU_DEPTH; i++) begin
         if (wb_act && live_q[i] && (ent_wr_q[i] == wb_wr)) begin
            live_d[i] = 1'b0;
         end
      end
      if (pop) begin
         live_d[head_q] = 1'b0;
         head_d         = ptr_inc(head_q);
      end
      if (enq) begin
         live_d[tail_q] = 1'b1;
         tail_d         = ptr_inc(tail_q);
      end
      case ({enq, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = ST_RUN;
               cnt_d   = 5'd0;
            end
         end
         ST_RUN: begin
            if (init_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !wb_we) begin
               state_d = ST_INIT;
               cnt_d   = 5'd0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= 5'd0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         live_q  <= live_d;
      end
   end

   always_ff @(posedge clk_50) begin
      if (enq) begin
         ent_wr_q[tail_q] <= npu_wr;
         ent_wd_q[tail_q] <= npu_wd;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized scoreboard bench for regfile_wr_arbiter: a queue-based reference model predicts
// each cycle's register-file write and status outputs, and a negedge monitor compares them.
module tb_regfile_wr_arbiter;

   localparam int NPU_DEPTH = 2;
   localparam int PH_INIT   = 0;
   localparam int PH_RUN    = 1;
   localparam int PH_DRAIN  = 2;

   logic        clk_50 = 1'b0;
   logic        rst;
   logic        init_req;
   logic [4:0]  init_addr;
   logic [31:0] init_data;
   logic        wb_we;
   logic [4:0]  wb_wr;
   logic [31:0] wb_wd;
   logic        npu_valid;
   logic [4:0]  npu_wr;
   logic [31:0] npu_wd;
   logic        npu_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        npu_raw;
   logic [4:0]  WR;
   logic [31:0] WD;
   logic        RegWrite;
   logic        stall;
   logic        init_done;

   always #10 clk_50 = ~clk_50;

   assign init_data = 32'hA000_0000 | {27'd0, init_addr};

   regfile_wr_arbiter #(.NPU_DEPTH(NPU_DEPTH)) dut (
      .clk_50    (clk_50),
      .rst       (rst),
      .init_req  (init_req),
      .init_addr (init_addr),
      .init_data (init_data),
      .wb_we     (wb_we),
      .wb_wr     (wb_wr),
      .wb_wd     (wb_wd),
      .npu_valid (npu_valid),
      .npu_wr    (npu_wr),
      .npu_wd    (npu_wd),
      .npu_ready (npu_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .npu_raw   (npu_raw),
      .WR        (WR),
      .WD        (WD),
      .RegWrite  (RegWrite),
      .stall     (stall),
      .init_done (init_done)
   );

   typedef struct {
      logic [4:0]  wr;
      logic [31:0] wd;
      bit          killed;
   } npu_ent_t;

   typedef struct {
      logic [4:0]  wr;
      logic [31:0] wd;
   } wr_exp_t;

   npu_ent_t model_fifo[$];
   wr_exp_t  exp_q[$];
   int       model_phase;
   int       model_cnt;
   logic     exp_stall;
   logic     exp_done;
   logic     exp_ready;
   logic     exp_raw;
   bit       checking = 1'b0;
   int       checks = 0;
   int       errors = 0;
   int       cycle = 0;

   bit       mon_exp_write;
   wr_exp_t  mon_ent;

   logic        r_rst, r_init_req, r_we, r_nv;
   logic [4:0]  r_wwr, r_nwr, r_rs1, r_rs2;
   logic [31:0] r_wwd, r_nwd;
   int          rst_hold;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic modelReset();
      model_phase = PH_INIT;
      model_cnt   = 0;
      model_fifo.delete();
   endtask

   // Drive one cycle of inputs, predict that cycle's outputs, then advance to the next cycle.
   task automatic applyStimulus(input logic a_rst, input logic a_init_req,
                                input logic a_we, input logic [4:0] a_wwr, input logic [31:0] a_wwd,
                                input logic a_nv, input logic [4:0] a_nwr, input logic [31:0] a_nwd,
                                input logic [4:0] a_rs1, input logic [4:0] a_rs2);
      int       sz;
      bit       wb_act;
      bit       head_killed;
      npu_ent_t head;
      rst       = a_rst;
      init_req  = a_init_req;
      wb_we     = a_we;
      wb_wr     = a_wwr;
      wb_wd     = a_wwd;
      npu_valid = a_nv;
      npu_wr    = a_nwr;
      npu_wd    = a_nwd;
      rs1       = a_rs1;
      rs2       = a_rs2;
      sz = model_fifo.size();
      if (model_phase == PH_INIT) begin
         exp_q.push_back('{5'(model_cnt), (model_cnt == 0) ? 32'd0 : (32'hA000_0000 | 32'(model_cnt))});
         exp_stall = 1'b1;
         exp_done  = 1'b0;
         exp_ready = 1'b0;
         exp_raw   = 1'b0;
         if (model_cnt == 31) begin
            model_phase = PH_RUN;
            model_cnt   = 0;
         end else begin
            model_cnt++;
         end
      end else begin
         exp_stall = (model_phase != PH_RUN);
         exp_done  = (model_phase == PH_RUN);
         exp_ready = (model_phase == PH_RUN) && (sz < NPU_DEPTH);
         exp_raw   = 1'b0;
         if (model_phase == PH_RUN) begin
            foreach (model_fifo[i]) begin
               if (!model_fifo[i].killed && ((model_fifo[i].wr == a_rs1) || (model_fifo[i].wr == a_rs2)))
                  exp_raw = 1'b1;
            end
         end
         wb_act = a_we && (a_wwr != 5'd0);
         if (wb_act) begin
            exp_q.push_back('{a_wwr, a_wwd});
            head_killed = (sz > 0) && model_fifo[0].killed;
            foreach (model_fifo[i]) begin
               if (model_fifo[i].wr == a_wwr) model_fifo[i].killed = 1'b1;
            end
            if (head_killed) void'(model_fifo.pop_front());
         end else if (sz > 0) begin
            head = model_fifo.pop_front();
            if (!head.killed) exp_q.push_back('{head.wr, head.wd});
         end
         if (exp_ready && a_nv && (a_nwr != 5'd0)) model_fifo.push_back('{a_nwr, a_nwd, 1'b0});
         if ((model_phase == PH_RUN) && a_init_req) begin
            model_phase = PH_DRAIN;
         end else if ((model_phase == PH_DRAIN) && (sz == 0) && !a_we) begin
            model_phase = PH_INIT;
            model_cnt   = 0;
         end
      end
      if (!a_rst) modelReset();
      @(posedge clk_50);
      #1;
      cycle++;
   endtask

   always @(negedge clk_50) begin
      if (checking) begin
         checkOutput("stall", 32'(stall), 32'(exp_stall));
         checkOutput("init_done", 32'(init_done), 32'(exp_done));
         checkOutput("npu_ready", 32'(npu_ready), 32'(exp_ready));
         checkOutput("npu_raw", 32'(npu_raw), 32'(exp_raw));
         mon_exp_write = (exp_q.size() > 0);
         checkOutput("RegWrite", 32'(RegWrite), 32'(mon_exp_write));
         if (mon_exp_write) begin
            mon_ent = exp_q.pop_front();
            if (RegWrite) begin
               checkOutput("WR", 32'(WR), 32'(mon_ent.wr));
               checkOutput("WD", WD, mon_ent.wd);
            end
         end else begin
            checkOutput("idle_WR", 32'(WR), 32'd0);
            checkOutput("idle_WD", WD, 32'd0);
         end
      end
   end

   initial begin
      rst       = 1'b0;
      init_req  = 1'b0;
      wb_we     = 1'b0;
      wb_wr     = 5'd0;
      wb_wd     = 32'd0;
      npu_valid = 1'b0;
      npu_wr    = 5'd0;
      npu_wd    = 32'd0;
      rs1       = 5'd0;
      rs2       = 5'd0;
      rst_hold  = 0;
      @(posedge clk_50);
      #1;
      modelReset();
      checking = 1'b1;

      // Reset held, then a sweep interrupted at cnt=17, then a full sweep.
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (17) applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66, 5'd0, 5'd0);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (33) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666, 5'd0, 5'd6);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, 5'd0, 5'd6);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd6);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD, 5'd9, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'hBEEF, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 5'd2, 32'h2222, 1'b1, 5'd10, 32'hA0A0, 5'd10, 5'd11);
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd2, 32'h2223, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      for (int n = 0; n < 4000; n++) begin
         if (rst_hold > 0) begin
            r_rst = 1'b0;
            rst_hold--;
         end else if ($urandom_range(0, 599) == 0) begin
            r_rst    = 1'b0;
            rst_hold = $urandom_range(0, 2);
         end else begin
            r_rst = 1'b1;
         end
         r_init_req = ($urandom_range(0, 149) == 0);
         r_we       = ($urandom_range(0, 99) < 40);
         r_wwr      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
         r_wwd      = $urandom;
         r_nv       = ($urandom_range(0, 99) < 55);
         r_nwr      = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
         r_nwd      = $urandom;
         r_rs1      = 5'($urandom_range(0, 9));
         r_rs2      = 5'($urandom_range(0, 9));
         applyStimulus(r_rst, r_init_req, r_we, r_wwr, r_wwd, r_nv, r_nwr, r_nwd, r_rs1, r_rs2);
      end

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
